// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver with a valid/ack holding register and framing/overrun flags.
// Define UART_CMD_RX_PARITY_EN to receive 8E1 frames (even parity checked before the stop bit).
module uart_cmd_rx #(
  parameter int CLK_FREQUENCY = 10000000,
  parameter int BAUD_RATE     = 57600
) (
  input  logic       clki,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       frame_error,
  output logic       overrun,
  output logic       busy
);

  localparam int DIV = CLK_FREQUENCY / BAUD_RATE;
  localparam int TW  = $clog2(DIV);

  localparam logic [TW-1:0] FULL_LOAD = TW'(DIV - 1);
  localparam logic [TW-1:0] HALF_LOAD = TW'(DIV / 2 - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
  localparam logic [2:0] S_BREAK  = 3'd4;
`ifdef UART_CMD_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd5;
`endif

  logic          sync1;
  logic          rxs;
  logic          rxs_d;
  logic          rxs_d2;
  logic [2:0]    state;
  logic [TW-1:0] timer;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          tick;
  logic          sample;
  logic          fall;
`ifdef UART_CMD_RX_PARITY_EN
  logic          parity_err;
`endif

  // Synchroniser idles high so reset never fabricates a start edge on an idle line.
  always_ff @(posedge clki or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= 1'b1;
      rxs    <= 1'b1;
      rxs_d  <= 1'b1;
      rxs_d2 <= 1'b1;
    end else begin
      sync1  <= rx;
      rxs    <= sync1;
      rxs_d  <= rxs;
      rxs_d2 <= rxs_d;
    end
  end

  assign tick   = (timer == '0);
  assign fall   = rxs_d & ~rxs;
  assign sample = (rxs & rxs_d) | (rxs & rxs_d2) | (rxs_d & rxs_d2);
  assign busy   = (state != S_IDLE);

  always_ff @(posedge clki or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      timer       <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
`ifdef UART_CMD_RX_PARITY_EN
      parity_err  <= 1'b0;
`endif
    end else begin
      frame_error <= 1'b0;
      overrun     <= 1'b0;
      if (rx_valid && rx_ack) rx_valid <= 1'b0;
      if (!tick) timer <= timer - TW'(1);

      case (state)
        S_IDLE: begin
          if (fall) begin
            timer <= HALF_LOAD;
            state <= S_START;
          end
        end

        S_START: begin
          if (tick) begin
            if (!sample) begin
              timer   <= FULL_LOAD;
              bit_cnt <= '0;
              state   <= S_DATA;
            end else begin
              state <= S_IDLE;
            end
          end
        end

        S_DATA: begin
          if (tick) begin
            shift_reg <= {sample, shift_reg[7:1]};
            timer     <= FULL_LOAD;
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef UART_CMD_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end
        end

`ifdef UART_CMD_RX_PARITY_EN
        S_PARITY: begin
          if (tick) begin
            parity_err <= (sample != ^shift_reg);
            timer      <= FULL_LOAD;
            state      <= S_STOP;
          end
        end
`endif

        // Leaving at mid-stop lets a back-to-back start edge be caught in IDLE.
        S_STOP: begin
          if (tick) begin
            if (!sample) begin
              frame_error <= 1'b1;
              timer       <= FULL_LOAD;
              state       <= S_BREAK;
`ifdef UART_CMD_RX_PARITY_EN
            end else if (parity_err) begin
              frame_error <= 1'b1;
              state       <= S_IDLE;
`endif
            end else begin
              state <= S_IDLE;
              if (!rx_valid || rx_ack) begin
                rx_data  <= shift_reg;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end
          end
        end

        S_BREAK: begin
          if (!rxs) begin
            timer <= FULL_LOAD;
          end else if (tick) begin
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Self-checking bench for uart_cmd_rx at DIV=16; expected bytes go through a scoreboard queue.
// Parity scenarios run only when UART_CMD_RX_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_uart_cmd_rx;

  localparam int CLK_FREQUENCY = 1600000;
  localparam int BAUD_RATE     = 100000;
  localparam int DIV           = 16;
`ifdef UART_CMD_RX_PARITY_EN
  localparam int LATENCY = 171;
  logic flip_parity = 1'b0;
`else
  localparam int LATENCY = 155;
`endif

  logic       clki    = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx      = 1'b1;
  logic       rx_ack  = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_error;
  logic       overrun;
  logic       busy;

  int checks   = 0;
  int errors   = 0;
  int fe_count = 0;
  int ov_count = 0;
  logic [7:0] exp_q[$];

  always #5 clki = ~clki;

  uart_cmd_rx #(
    .CLK_FREQUENCY(CLK_FREQUENCY),
    .BAUD_RATE(BAUD_RATE)
  ) dut (
    .clki(clki),
    .reset_n(reset_n),
    .rx(rx),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ack(rx_ack),
    .frame_error(frame_error),
    .overrun(overrun),
    .busy(busy)
  );

  always @(negedge clki) begin
    if (frame_error) fe_count++;
    if (overrun) ov_count++;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clki);
    #1;
  endtask

  function automatic logic [7:0] pop_expected();
    if (exp_q.size() == 0) return 8'hxx;
    return exp_q.pop_front();
  endfunction

  // Line is left at the stop-bit level so callers can extend a low stop into a break.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic accept);
    if (accept) exp_q.push_back(data);
    rx = 1'b0;
    wait_cycles(DIV);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      wait_cycles(DIV);
    end
`ifdef UART_CMD_RX_PARITY_EN
    rx = (^data) ^ flip_parity;
    wait_cycles(DIV);
`endif
    rx = stop_bit;
    wait_cycles(DIV);
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (rx_valid !== 1'b1 && cycles < 400) begin
      @(posedge clki);
      #1;
      cycles++;
    end
  endtask

  task automatic test_reset();
    wait_cycles(3);
    checks++;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", rx_valid); end
    checks++;
    if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", rx_data); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++;
    if ({frame_error, overrun} !== 2'b00) begin
      errors++; $display("FAIL reset_flags got %b want 00", {frame_error, overrun});
    end
    reset_n = 1'b1;
    wait_cycles(3);
  endtask

  task automatic test_single_byte();
    int lat;
    int fe0 = fe_count;
    int ov0 = ov_count;
    fork
      send_frame(8'hA5, 1'b1, 1'b1);
      wait_valid(lat);
    join
    checks++;
    if (lat < LATENCY - 1 || lat > LATENCY + 1) begin
      errors++; $display("FAIL single_latency got %0d want %0d+-1", lat, LATENCY);
    end
    checks++;
    if (rx_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", rx_valid); end
    begin
      logic [7:0] exp = pop_expected();
      checks++;
      if (rx_data !== exp) begin errors++; $display("FAIL single_data got %h want %h", rx_data, exp); end
    end
    checks++;
    if (fe_count - fe0 != 0 || ov_count - ov0 != 0) begin
      errors++; $display("FAIL single_flags got fe %0d ov %0d want 0 0", fe_count - fe0, ov_count - ov0);
    end
    rx_ack = 1'b1;
    wait_cycles(1);
    rx_ack = 1'b0;
    checks++;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL single_ack got %b want 0", rx_valid); end
  endtask

  task automatic test_back_to_back();
    int fe0 = fe_count;
    int ov0 = ov_count;
    send_frame(8'h3C, 1'b1, 1'b1);
    send_frame(8'h7E, 1'b1, 1'b0);
    wait_cycles(4);
    checks++;
    if (ov_count - ov0 != 1) begin errors++; $display("FAIL b2b_overrun got %0d want 1", ov_count - ov0); end
    checks++;
    if (rx_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b want 1", rx_valid); end
    begin
      logic [7:0] exp = pop_expected();
      checks++;
      if (rx_data !== exp) begin errors++; $display("FAIL b2b_data got %h want %h", rx_data, exp); end
    end
    checks++;
    if (fe_count - fe0 != 0) begin errors++; $display("FAIL b2b_frame_error got %0d want 0", fe_count - fe0); end
    rx_ack = 1'b1;
    wait_cycles(1);
    rx_ack = 1'b0;
  endtask

  // Ack lands on the exact completion cycle of the second byte.
  task automatic test_ack_collision();
    int lat;
    int ov0;
    fork
      send_frame(8'h11, 1'b1, 1'b1);
      wait_valid(lat);
    join
    begin
      logic [7:0] exp = pop_expected();
      checks++;
      if (rx_data !== exp) begin errors++; $display("FAIL collide_first got %h want %h", rx_data, exp); end
    end
    ov0 = ov_count;
    fork
      send_frame(8'h22, 1'b1, 1'b1);
      begin
        wait_cycles(LATENCY - 1);
        rx_ack = 1'b1;
        wait_cycles(1);
        rx_ack = 1'b0;
      end
    join
    checks++;
    if (rx_valid !== 1'b1) begin errors++; $display("FAIL collide_valid got %b want 1", rx_valid); end
    begin
      logic [7:0] exp = pop_expected();
      checks++;
      if (rx_data !== exp) begin errors++; $display("FAIL collide_data got %h want %h", rx_data, exp); end
    end
    checks++;
    if (ov_count - ov0 != 0) begin errors++; $display("FAIL collide_overrun got %0d want 0", ov_count - ov0); end
    rx_ack = 1'b1;
    wait_cycles(1);
    rx_ack = 1'b0;
  endtask

  task automatic test_frame_error();
    int fe0 = fe_count;
    send_frame(8'h55, 1'b0, 1'b0);
    wait_cycles(40 * DIV);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL break_busy got %b want 1", busy); end
    checks++;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL break_valid got %b want 0", rx_valid); end
    rx = 1'b1;
    wait_cycles(10);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL break_hold got %b want 1", busy); end
    wait_cycles(14);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL break_exit got %b want 0", busy); end
    checks++;
    if (fe_count - fe0 != 1) begin errors++; $display("FAIL break_pulses got %0d want 1", fe_count - fe0); end
  endtask

  task automatic test_glitch();
    int fe0 = fe_count;
    int ov0 = ov_count;
    rx = 1'b0;
    wait_cycles(5);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL glitch_start got %b want 1", busy); end
    rx = 1'b1;
    wait_cycles(10);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL glitch_idle got %b want 0", busy); end
    checks++;
    if (fe_count - fe0 != 0 || ov_count - ov0 != 0 || rx_valid !== 1'b0) begin
      errors++; $display("FAIL glitch_flags got fe %0d ov %0d valid %b want 0 0 0",
                         fe_count - fe0, ov_count - ov0, rx_valid);
    end
  endtask

  task automatic test_reset_midframe();
    int lat;
    send_frame(8'h5A, 1'b1, 1'b1);
    begin
      logic [7:0] exp = pop_expected();
      checks++;
      if (rx_data !== exp) begin errors++; $display("FAIL midreset_pre got %h want %h", rx_data, exp); end
    end
    rx = 1'b0;
    wait_cycles(DIV);
    rx = 1'b1;
    wait_cycles(3 * DIV);
    reset_n = 1'b0;
    #2;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", busy); end
    checks++;
    if ({rx_valid, frame_error, overrun, rx_data} !== 11'd0) begin
      errors++; $display("FAIL midreset_outputs got %b want 0", {rx_valid, frame_error, overrun, rx_data});
    end
    wait_cycles(2);
    reset_n = 1'b1;
    wait_cycles(7 * DIV);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL midreset_tail got %b want 0", busy); end
    fork
      send_frame(8'h81, 1'b1, 1'b1);
      wait_valid(lat);
    join
    checks++;
    if (lat < LATENCY - 1 || lat > LATENCY + 1) begin
      errors++; $display("FAIL midreset_latency got %0d want %0d+-1", lat, LATENCY);
    end
    begin
      logic [7:0] exp = pop_expected();
      checks++;
      if (rx_data !== exp) begin errors++; $display("FAIL midreset_data got %h want %h", rx_data, exp); end
    end
    rx_ack = 1'b1;
    wait_cycles(1);
    rx_ack = 1'b0;
  endtask

`ifdef UART_CMD_RX_PARITY_EN
  task automatic test_parity();
    int fe0;
    flip_parity = 1'b0;
    send_frame(8'h03, 1'b1, 1'b1);
    wait_cycles(2);
    checks++;
    if (rx_valid !== 1'b1) begin errors++; $display("FAIL parity_ok_valid got %b want 1", rx_valid); end
    begin
      logic [7:0] exp = pop_expected();
      checks++;
      if (rx_data !== exp) begin errors++; $display("FAIL parity_ok_data got %h want %h", rx_data, exp); end
    end
    rx_ack = 1'b1;
    wait_cycles(1);
    rx_ack = 1'b0;
    fe0 = fe_count;
    flip_parity = 1'b1;
    send_frame(8'h03, 1'b1, 1'b0);
    wait_cycles(4);
    flip_parity = 1'b0;
    checks++;
    if (fe_count - fe0 != 1) begin errors++; $display("FAIL parity_bad_fe got %0d want 1", fe_count - fe0); end
    checks++;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL parity_bad_valid got %b want 0", rx_valid); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_ack_collision();
    test_frame_error();
    test_glitch();
    test_reset_midframe();
`ifdef UART_CMD_RX_PARITY_EN
    test_parity();
`endif
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_left got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
